fu_divsqrt_srt_iter: RTL and testbench

Parametrised radix-2 SRT iteration engine for unsigned normalised-fraction division in the FU divide/sqrt path. It generalises the single-digit quotient-select table into a full sequential divider. Each cycle it selects a digit q ∈ {-1, 0, +1} from the top bits of the shifted partial remainder and accumulates the quotient with on-the-fly conversion. A final cycle applies sign correction so the block delivers exact floor quotient and remainder through a start/ready/done handshake.

---
 rtl/fu_divsqrt_srt_iter.sv | 158 +++++++++++++++
 tb/tb_fu_divsqrt_srt_iter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_divsqrt_srt_iter.sv
// Radix-2 SRT sequential divider for normalised unsigned fractions: digit set {-1,0,+1},
// on-the-fly quotient conversion and a final sign-correction cycle giving exact floor q/rem.
module fu_divsqrt_srt_iter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dv_q, dv_d;
  logic [WIDTH+1:0]   r_q, r_d;
  logic [WIDTH-1:0]   qa_q, qa_d;
  logic [WIDTH-1:0]   qm_q, qm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               err_q, err_d;

  logic [WIDTH+1:0]   s;
  logic [WIDTH+1:0]   d_ext;
  logic               dig_pos, dig_neg;
  logic               ops_legal;

  // Handshake: a launch happens on a rising edge where start=1, ready=1 and kill=0;
  // done is a one-cycle pulse and q/rem/err are valid from that cycle until the next launch.
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign q         = q_q;
  assign rem       = rem_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign s     = {r_q[WIDTH:0], 1'b0};
  assign d_ext = {2'b00, dv_q};

  // Digit select from sign plus two top magnitude bits: s >= 1/2 -> +1, s < -1/2 -> -1.
  assign dig_pos = ~s[WIDTH+1] & (s[WIDTH] | s[WIDTH-1]);
  assign dig_neg =  s[WIDTH+1] & ~(s[WIDTH] & s[WIDTH-1]);

  assign ops_legal = d[WIDTH-1] & (a < d);

  always_comb begin
    state_d = state_q;
    dv_d    = dv_q;
    r_d     = r_q;
    qa_d    = qa_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (ops_legal) begin
              dv_d    = d;
              r_d     = {2'b00, a};
              qa_d    = '0;
              qm_d    = '0;
              cnt_d   = '0;
              state_d = S_ITER;
            end else begin
              q_d     = '0;
              rem_d   = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_ITER: begin
          if (dig_pos) begin
            r_d  = s - d_ext;
            qa_d = {qa_q[WIDTH-2:0], 1'b1};
            qm_d = {qa_q[WIDTH-2:0], 1'b0};
          end else if (dig_neg) begin
            r_d  = s + d_ext;
            qa_d = {qm_q[WIDTH-2:0], 1'b1};
            qm_d = {qm_q[WIDTH-2:0], 1'b0};
          end else begin
            r_d  = s;
            qa_d = {qa_q[WIDTH-2:0], 1'b0};
            qm_d = {qm_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          // A negative final remainder means the redundant quotient overshot by one.
          if (r_q[WIDTH+1]) begin
            q_d   = qm_q;
            rem_d = r_q[WIDTH-1:0] + dv_q;
          end else begin
            q_d   = qa_q;
            rem_d = r_q[WIDTH-1:0];
          end
          err_d   = 1'b0;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      dv_q    <= '0;
      r_q     <= '0;
      qa_q    <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      r_q     <= r_d;
      qa_q    <= qa_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fu_divsqrt_srt_iter.sv
// Directed-vector bench for fu_divsqrt_srt_iter at WIDTH=8, plus kill/reset/ignored-start
// sequences and a short back-to-back run checked against a*2^8 div/mod d.
module tb_fu_divsqrt_srt_iter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b, start, kill;
  logic [W-1:0] a, d, q, rem;
  logic         ready, done, err;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ee;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  fu_divsqrt_srt_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .kill      (kill),
    .a         (a),
    .d         (d),
    .ready     (ready),
    .done      (done),
    .q         (q),
    .rem       (rem),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] dv);
    @(negedge clk);
    a     = av;
    d     = dv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= budget) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
  endtask

  task automatic no_done(input int n, input string tag);
    bit hit = 1'b0;
    repeat (n) begin
      step();
      if (done !== 1'b0) hit = 1'b1;
    end
    check(tag, 64'(hit), 64'(0));
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] dv, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ee, input int elat, input string tag);
    int lat;
    bit seen;
    launch(av, dv);
    check({tag, " ready_low"}, 64'(ready), 64'(0));
    wait_done(40, lat, seen);
    check({tag, " done_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " q"}, 64'(q), 64'(eq));
      check({tag, " rem"}, 64'(rem), 64'(er));
      check({tag, " err"}, 64'(err), 64'(ee));
    end
    step();
    check({tag, " done_pulse"}, 64'(done), 64'(0));
    check({tag, " ready_back"}, 64'(ready), 64'(1));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [W-1:0] ra, rd, req, rer;
    logic         ree;
    int           num;

    vecs[0]  = '{8'h40, 8'h80, 8'h80, 8'h00, 1'b0, 10};
    vecs[1]  = '{8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b0, 10};
    vecs[2]  = '{8'h01, 8'hFF, 8'h01, 8'h01, 1'b0, 10};
    vecs[3]  = '{8'h00, 8'h80, 8'h00, 8'h00, 1'b0, 10};
    vecs[4]  = '{8'h7F, 8'h80, 8'hFE, 8'h00, 1'b0, 10};
    vecs[5]  = '{8'h12, 8'h9D, 8'h1D, 8'h37, 1'b0, 10};
    vecs[6]  = '{8'h9C, 8'h9D, 8'hFE, 8'h3A, 1'b0, 10};
    vecs[7]  = '{8'h80, 8'hC0, 8'hAA, 8'h80, 1'b0, 10};
    vecs[8]  = '{8'h01, 8'h80, 8'h02, 8'h00, 1'b0, 10};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1};
    vecs[10] = '{8'h55, 8'hAA, 8'h80, 8'h00, 1'b0, 10};
    vecs[11] = '{8'h10, 8'h7F, 8'h00, 8'h00, 1'b1, 1};
    vecs[12] = '{8'h90, 8'h90, 8'h00, 8'h00, 1'b1, 1};
    vecs[13] = '{8'hFF, 8'h80, 8'h00, 8'h00, 1'b1, 1};
    vecs[14] = '{8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b0, 10};

    rst_b = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    a     = '0;
    d     = '0;
    step();
    step();
    check("reset q", 64'(q), 64'(0));
    check("reset rem", 64'(rem), 64'(0));
    check("reset err", 64'(err), 64'(0));
    check("reset ready", 64'(ready), 64'(1));
    check("reset done", 64'(done), 64'(0));
    check("reset state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].d, vecs[i].eq, vecs[i].er, vecs[i].ee, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // kill in the 4th ITER cycle after a start pulse mid-ITER
    run_op(8'h12, 8'h9D, 8'h1D, 8'h37, 1'b0, 10, "pre_kill");
    launch(8'hFE, 8'hFF);
    step();
    @(negedge clk);
    start = 1'b1;
    a     = 8'h40;
    d     = 8'h80;
    step();
    start = 1'b0;
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill ready", 64'(ready), 64'(1));
    check("kill done", 64'(done), 64'(0));
    check("kill q_hold", 64'(q), 64'(8'h1D));
    check("kill rem_hold", 64'(rem), 64'(8'h37));
    no_done(14, "kill no_done");

    // start pulsed mid-ITER is ignored
    launch(8'h01, 8'hFF);
    step();
    @(negedge clk);
    start = 1'b1;
    a     = 8'h40;
    d     = 8'h80;
    step();
    start = 1'b0;
    wait_done(40, lat, seen);
    check("ign done_seen", 64'(seen), 64'(1));
    check("ign latency", 64'(lat + 2), 64'(10));
    check("ign q", 64'(q), 64'(8'h01));
    check("ign rem", 64'(rem), 64'(8'h01));
    check("ign err", 64'(err), 64'(0));
    no_done(14, "ign no_second_done");

    // start and kill together in IDLE: nothing launches
    @(negedge clk);
    start = 1'b1;
    kill  = 1'b1;
    a     = 8'h00;
    d     = 8'h00;
    step();
    start = 1'b0;
    kill  = 1'b0;
    check("kill_start ready", 64'(ready), 64'(1));
    check("kill_start err_hold", 64'(err), 64'(0));
    no_done(12, "kill_start no_done");

    // reset mid-ITER, then a normal op
    launch(8'hFE, 8'hFF);
    step();
    step();
    @(negedge clk);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check("midrst q", 64'(q), 64'(0));
    check("midrst rem", 64'(rem), 64'(0));
    check("midrst err", 64'(err), 64'(0));
    check("midrst ready", 64'(ready), 64'(1));
    check("midrst done", 64'(done), 64'(0));
    run_op(8'h01, 8'hFF, 8'h01, 8'h01, 1'b0, 10, "post_rst");

    // back-to-back random ops against a*2^W div/mod d
    for (int i = 0; i < 200; i++) begin
      rd = 8'($urandom_range(128, 255));
      if (i % 10 == 9) begin
        ra  = rd;
        req = '0;
        rer = '0;
        ree = 1'b1;
      end else begin
        ra  = 8'($urandom_range(0, 32'(rd) - 1));
        num = 32'(ra) * 256;
        req = 8'(num / 32'(rd));
        rer = 8'(num % 32'(rd));
        ree = 1'b0;
      end
      run_op(ra, rd, req, rer, ree, ree ? 1 : 10, $sformatf("rnd%0d a=%0h d=%0h", i, ra, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
